// File: rtl/mult6_seq_if.sv
// Start/done handshake bundle for the sequential digit multiplier.
// The requester drives start and the operands; the multiplier returns status and the product.
interface mult6_seq_if #(
  parameter int N_DIG = 2
);
  localparam int W = 3 * N_DIG;

  logic             start;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   product;

  modport master (
    output start,
    output a,
    output b,
    input  busy,
    input  done,
    input  product
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output busy,
    output done,
    output product
  );
endinterface

// File: rtl/mult6_seq.sv
// Sequential wide unsigned multiplier built around one shared 3x3 combinational multiplier.
// Operands are split into 3-bit digits and one digit pair is multiplied per cycle; the
// shifted partial products are summed into an accumulator and published on DONE entry.

// 3x3 unsigned combinational multiplier, 6-bit result.
module multiplier3 (
  input  logic [2:0] x,
  input  logic [2:0] y,
  output logic [5:0] p
);
  assign p = {3'b000, x} * {3'b000, y};
endmodule

module mult6_seq #(
  parameter int N_DIG = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  mult6_seq_if.slave  bus
);
  localparam int W      = 3 * N_DIG;
  localparam int PW     = 2 * W;
  localparam int NSTEP  = N_DIG * N_DIG;
  localparam int STEP_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEP - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              accept;
  logic              last_step;

  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic [PW-1:0]     acc_q;
  logic [PW-1:0]     product_q;
  logic [STEP_W-1:0] step_q;

  logic [STEP_W-1:0] dig_i;
  logic [STEP_W-1:0] dig_j;
  logic [2:0]        a_dig;
  logic [2:0]        b_dig;
  logic [5:0]        pprod;
  logic [PW-1:0]     term;
  logic [PW-1:0]     acc_sum;

  // Digit selection: a-digit is the outer index, b-digit the inner one.
  assign dig_i = STEP_W'(step_q / STEP_W'(N_DIG));
  assign dig_j = STEP_W'(step_q % STEP_W'(N_DIG));
  assign a_dig = 3'(a_q >> (3 * 32'(dig_i)));
  assign b_dig = 3'(b_q >> (3 * 32'(dig_j)));

  multiplier3 u_mult3 (
    .x (a_dig),
    .y (b_dig),
    .p (pprod)
  );

  // Partial product is zero-extended to full product width before weighting by its digit position.
  assign term    = PW'(pprod) << (3 * (32'(dig_i) + 32'(dig_j)));
  assign acc_sum = acc_q + term;

  assign last_step = (step_q == LAST_STEP);

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake decode; a new op may be accepted from IDLE or straight out of DONE.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (last_step) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand latch, digit-step counter, accumulator and published product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      step_q    <= '0;
      product_q <= '0;
    end else if (accept) begin
      a_q    <= bus.a;
      b_q    <= bus.b;
      acc_q  <= '0;
      step_q <= '0;
    end else if (state_q == CALC) begin
      acc_q <= acc_sum;
      if (last_step) begin
        // The counter parks on the final step instead of wrapping.
        product_q <= acc_sum;
      end else begin
        step_q <= step_q + 1'b1;
      end
    end
  end

  assign bus.busy    = (state_q == CALC);
  assign bus.done    = (state_q == DONE);
  assign bus.product = product_q;

endmodule

// File: tb/tb_mult6_seq.sv
// Directed self-checking bench for mult6_seq: default 2-digit build plus 1- and 3-digit builds.
module tb_mult6_seq;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  mult6_seq_if #(.N_DIG(2)) bus  ();
  mult6_seq_if #(.N_DIG(1)) bus1 ();
  mult6_seq_if #(.N_DIG(3)) bus3 ();

  mult6_seq #(.N_DIG(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  mult6_seq #(.N_DIG(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  mult6_seq #(.N_DIG(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation on the 2-digit DUT; reports product, cycles from accept to done, timeout.
  task automatic do_op(input logic [5:0] a, input logic [5:0] b,
                       output logic [11:0] prod, output int lat, output bit tmo);
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 0;
    tmo = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      lat++;
      if (bus.done) begin
        tmo = 1'b0;
        break;
      end
    end
    prod = bus.product;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;  bus.a = '0;  bus.b = '0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0;
    bus3.start = 1'b0; bus3.a = '0; bus3.b = '0;
    tick();
    tick();
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_checks++;
    if (bus.done !== 1'b0) begin n_fails++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    n_checks++;
    if (bus.product !== 12'd0) begin n_fails++; $display("FAIL reset_product got=%0d exp=0", bus.product); end
    n_checks++;
    if (bus3.product !== 18'd0) begin n_fails++; $display("FAIL reset_product_n3 got=%0d exp=0", bus3.product); end
    #2;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fails++; $display("FAIL idle_after_reset busy=%b done=%b exp=0,0", bus.busy, bus.done);
    end
  endtask

  task automatic test_basic_timing();
    bus.a = 6'd5;
    bus.b = 6'd6;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int e = 0; e < 4; e++) begin
      n_checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        n_fails++; $display("FAIL calc_status E%0d busy=%b done=%b exp=1,0", e, bus.busy, bus.done);
      end
      tick();
    end
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin
      n_fails++; $display("FAIL done_status busy=%b done=%b exp=0,1", bus.busy, bus.done);
    end
    n_checks++;
    if (bus.product !== 12'h01E) begin n_fails++; $display("FAIL product_5x6 got=%0d exp=30", bus.product); end
    tick();
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fails++; $display("FAIL done_one_cycle busy=%b done=%b exp=0,0", bus.busy, bus.done);
    end
    n_checks++;
    if (bus.product !== 12'h01E) begin n_fails++; $display("FAIL product_hold got=%0d exp=30", bus.product); end
  endtask

  task automatic test_vectors();
    logic [5:0]  va [3];
    logic [5:0]  vb [3];
    logic [11:0] ve [3];
    logic [11:0] prod;
    int          lat;
    bit          tmo;
    va[0] = 6'd63; vb[0] = 6'd63; ve[0] = 12'hF81;
    va[1] = 6'd0;  vb[1] = 6'd45; ve[1] = 12'h000;
    va[2] = 6'd45; vb[2] = 6'd27; ve[2] = 12'h4BF;
    for (int v = 0; v < 3; v++) begin
      do_op(va[v], vb[v], prod, lat, tmo);
      n_checks++;
      if (tmo || prod !== ve[v]) begin
        n_fails++; $display("FAIL vector_%0dx%0d got=%0d exp=%0d timeout=%0d", va[v], vb[v], prod, ve[v], tmo);
      end
      n_checks++;
      if (lat !== 4) begin n_fails++; $display("FAIL latency_vec%0d got=%0d exp=4", v, lat); end
      tick();
    end
  endtask

  task automatic test_ignore_inputs();
    int lat;
    int extra_done;
    bit seen;
    bus.a = 6'd45;
    bus.b = 6'd27;
    bus.start = 1'b1;
    tick();
    lat = 0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      bus.start = k[0] ? 1'b0 : 1'b1;
      bus.a = 6'(k * 11 + 3);
      bus.b = 6'(k * 5 + 60);
      tick();
      lat++;
      if (bus.done) begin
        seen = 1'b1;
        bus.start = 1'b0;
        break;
      end
    end
    n_checks++;
    if (!seen || bus.product !== 12'd1215) begin
      n_fails++; $display("FAIL latched_operands got=%0d exp=1215 seen=%0d", bus.product, seen);
    end
    n_checks++;
    if (lat !== 4) begin n_fails++; $display("FAIL no_restart_latency got=%0d exp=4", lat); end
    extra_done = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.done) extra_done++;
    end
    n_checks++;
    if (extra_done !== 0) begin n_fails++; $display("FAIL single_done extra=%0d exp=0", extra_done); end
  endtask

  task automatic test_back_to_back();
    logic exp_done;
    bus.a = 6'd7;
    bus.b = 6'd9;
    bus.start = 1'b1;
    tick();
    for (int t = 1; t <= 14; t++) begin
      tick();
      exp_done = ((t % 5) == 4);
      n_checks++;
      if (bus.done !== exp_done || bus.busy !== !exp_done) begin
        n_fails++; $display("FAIL b2b_t%0d done=%b busy=%b exp_done=%b", t, bus.done, bus.busy, exp_done);
      end
      if (exp_done) begin
        n_checks++;
        if (bus.product !== 12'd63) begin n_fails++; $display("FAIL b2b_product_t%0d got=%0d exp=63", t, bus.product); end
      end
    end
    bus.start = 1'b0;
    tick();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fails++; $display("FAIL b2b_to_idle busy=%b done=%b exp=0,0", bus.busy, bus.done);
    end
  endtask

  task automatic test_reset_abort();
    logic [11:0] prod;
    int          lat;
    bit          tmo;
    int          late_done;
    bus.a = 6'd45;
    bus.b = 6'd27;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 12'd0) begin
      n_fails++; $display("FAIL abort_immediate busy=%b done=%b product=%0d exp=0,0,0", bus.busy, bus.done, bus.product);
    end
    #2;
    rst_n = 1'b1;
    late_done = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.done || bus.busy) late_done++;
    end
    n_checks++;
    if (late_done !== 0) begin n_fails++; $display("FAIL abort_no_done activity=%0d exp=0", late_done); end
    do_op(6'd45, 6'd27, prod, lat, tmo);
    n_checks++;
    if (tmo || prod !== 12'd1215) begin n_fails++; $display("FAIL after_abort got=%0d exp=1215", prod); end
    tick();
  endtask

  task automatic test_exhaustive();
    logic [11:0] prod;
    int          lat;
    bit          tmo;
    logic [11:0] ref_p;
    for (int ia = 0; ia < 64; ia++) begin
      for (int ib = 0; ib < 64; ib++) begin
        ref_p = 12'(ia * ib);
        do_op(6'(ia), 6'(ib), prod, lat, tmo);
        n_checks++;
        if (tmo || prod !== ref_p || lat !== 4) begin
          n_fails++; $display("FAIL exh_%0dx%0d got=%0d exp=%0d lat=%0d", ia, ib, prod, ref_p, lat);
        end
      end
    end
    tick();
  endtask

  task automatic test_other_widths();
    int lat;
    bit seen;
    // 1-digit build: 3x3, one multiply cycle.
    bus1.a = 3'd7;
    bus1.b = 3'd7;
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    n_checks++;
    if (bus1.busy !== 1'b1) begin n_fails++; $display("FAIL n1_busy got=%b exp=1", bus1.busy); end
    tick();
    n_checks++;
    if (bus1.done !== 1'b1 || bus1.product !== 6'd49) begin
      n_fails++; $display("FAIL n1_7x7 done=%b got=%0d exp=49", bus1.done, bus1.product);
    end
    bus1.a = 3'd5;
    bus1.b = 3'd6;
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    tick();
    n_checks++;
    if (bus1.done !== 1'b1 || bus1.product !== 6'd30) begin
      n_fails++; $display("FAIL n1_5x6 done=%b got=%0d exp=30", bus1.done, bus1.product);
    end
    // 3-digit build: 9x9, nine multiply cycles.
    bus3.a = 9'd511;
    bus3.b = 9'd511;
    bus3.start = 1'b1;
    tick();
    bus3.start = 1'b0;
    lat = 0;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      lat++;
      if (bus3.done) begin seen = 1'b1; break; end
    end
    n_checks++;
    if (!seen || lat !== 9 || bus3.product !== 18'd261121) begin
      n_fails++; $display("FAIL n3_511x511 got=%0d exp=261121 lat=%0d", bus3.product, lat);
    end
    bus3.a = 9'd300;
    bus3.b = 9'd17;
    bus3.start = 1'b1;
    tick();
    bus3.start = 1'b0;
    lat = 0;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      lat++;
      if (bus3.done) begin seen = 1'b1; break; end
    end
    n_checks++;
    if (!seen || lat !== 9 || bus3.product !== 18'd5100) begin
      n_fails++; $display("FAIL n3_300x17 got=%0d exp=5100 lat=%0d", bus3.product, lat);
    end
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    test_reset();
    test_basic_timing();
    test_vectors();
    test_ignore_inputs();
    test_back_to_back();
    test_reset_abort();
    test_other_widths();
    test_exhaustive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
